// File: rtl/ram8_access_ctrl_if.sv
// Request/response channel and RAM8 port bundle for ram8_access_ctrl.
// The controller takes the slave side; the requester/RAM side takes master.
interface ram8_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_addr;
  logic [15:0] req_wdata;
  logic        clear;
  logic        busy;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [2:0]  ram_address;
  logic [15:0] ram_out;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, clear, rsp_ready, ram_out,
    output req_ready, busy, rsp_valid, rsp_rdata, ram_in, ram_load, ram_address
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, clear, rsp_ready, ram_out,
    input  req_ready, busy, rsp_valid, rsp_rdata, ram_in, ram_load, ram_address
  );
endinterface

// File: rtl/ram8_access_ctrl.sv
// Request sequencer in front of an 8 x 16 RAM8: single-word read/write
// requests, registered read response, and a fill sweep after reset / clear.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_FILL  | writing CLEAR_VALUE to addresses 0..7, one per cycle
// S_IDLE  | waiting for clear or a request; only state with req_ready
// S_WRITE | ram_load high for one cycle at the captured address
// S_READ  | captured address on ram_address, ram_out sampled at cycle end
// S_RESP  | rsp_valid held with stable rsp_rdata until rsp_ready
module ram8_access_ctrl #(
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [15:0] CLEAR_VALUE    = 16'h0000
) (
  input logic              CLK,
  input logic              RESET_N,
  ram8_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_FILL  = 3'd0,
    S_IDLE  = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_FILL : S_IDLE;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        load_q, load_d;
  logic [2:0]  addr_q, addr_d;
  logic [15:0] in_q, in_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        req_ready;

  // RESET_N is folded in so nothing is accepted while reset is asserted.
  assign req_ready = RESET_N && (state_q == S_IDLE) && !bus.clear;

  // State and all registered outputs; reset forces the RAM port quiet at once.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= RESET_STATE;
      cnt_q       <= 3'd0;
      load_q      <= 1'b0;
      addr_q      <= 3'd0;
      in_q        <= 16'h0000;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 16'h0000;
      busy_q      <= CLEAR_ON_RESET;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      load_q      <= load_d;
      addr_q      <= addr_d;
      in_q        <= in_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
    end
  end

  // Next state plus the RAM port values for the cycle being entered.
  // The RAM outputs are registered, so each branch sets what the next
  // cycle should present; addr_q doubles as the captured request address.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_d      = 1'b0;
    addr_d      = 3'd0;
    in_d        = 16'h0000;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;

    case (state_q)
      S_FILL: begin
        // After reset the first FILL cycle has load low; the sweep then
        // issues cnt_q = 0..7 and leaves once address 7 has been written.
        if (load_q && (addr_q == 3'd7)) begin
          state_d = S_IDLE;
        end else begin
          load_d = 1'b1;
          addr_d = cnt_q;
          in_d   = CLEAR_VALUE;
          cnt_d  = cnt_q + 3'd1;
        end
      end
      S_IDLE: begin
        if (bus.clear) begin
          state_d = S_FILL;
          load_d  = 1'b1;
          addr_d  = 3'd0;
          in_d    = CLEAR_VALUE;
          cnt_d   = 3'd1;
        end else if (bus.req_valid && req_ready) begin
          addr_d = bus.req_addr;
          if (bus.req_write) begin
            state_d = S_WRITE;
            load_d  = 1'b1;
            in_d    = bus.req_wdata;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      S_READ: begin
        addr_d      = addr_q;
        rsp_valid_d = 1'b1;
        rdata_d     = bus.ram_out;
        state_d     = S_RESP;
      end
      S_RESP: begin
        addr_d = addr_q;
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          addr_d      = 3'd0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign bus.req_ready   = req_ready;
  assign bus.busy        = busy_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.ram_in      = in_q;
  assign bus.ram_load    = load_q;
  assign bus.ram_address = addr_q;

endmodule
